// File: rtl/ov7670_fb_writer_if.sv
// Pixel stream from the OV7670 capture block into the framebuffer writer.
// The capture side drives through master; the writer samples through slave.
interface ov7670_fb_writer_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_sof;
    logic        in_eol;

    modport master (
        output in_valid,
        output in_data,
        output in_sof,
        output in_eol
    );

    modport slave (
        input in_valid,
        input in_data,
        input in_sof,
        input in_eol
    );
endinterface

// File: rtl/ov7670_fb_writer.sv
// RGB565 capture stream -> decimated RGB332 framebuffer writes (pclk_12 domain).
// Define OV7670_FB_WRITER_ROUND_EN for round-to-nearest colour conversion.
module ov7670_fb_writer #(
    parameter int SRC_W = 640,
    parameter int SRC_H = 480,
    parameter int DEC   = 4,
    parameter int AW    = 15
) (
    input  logic                pclk_12,
    input  logic                reset_n,
    input  logic                enable,
    ov7670_fb_writer_if.slave   pix,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [7:0]          wr_data,
    output logic                busy,
    output logic                frame_done
);
    localparam int XW = $clog2(SRC_W + 1);
    localparam int YW = $clog2(SRC_H + 1);
    localparam int OW = SRC_W / DEC;

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

    state_t state, state_d;

    logic [XW-1:0] src_x, cx;
    logic [YW-1:0] src_y, cy;
    logic [AW-1:0] line_base, out_x, base, ox;
    logic          sof_beat, beat, col_kept, row_kept, keep, eof;
    logic [7:0]    rgb;
    logic          unused_data;

    assign unused_data = ^pix.in_data;

    // A start-of-frame beat is treated as pixel (0,0) regardless of counters.
    assign sof_beat = pix.in_valid & pix.in_sof &
                      ((state == ACTIVE) | ((state == ARMED) & enable));
    assign beat     = pix.in_valid & ((state == ACTIVE) | sof_beat);

    assign cx   = sof_beat ? '0 : src_x;
    assign cy   = sof_beat ? '0 : src_y;
    assign base = sof_beat ? '0 : line_base;
    assign ox   = sof_beat ? '0 : out_x;

    assign col_kept = ((cx & XW'(DEC - 1)) == '0) & (cx < XW'(SRC_W));
    assign row_kept = ((cy & YW'(DEC - 1)) == '0) & (cy < YW'(SRC_H));
    assign keep     = beat & col_kept & row_kept;
    assign eof      = beat & pix.in_eol & (cy == YW'(SRC_H - 1));

`ifdef OV7670_FB_WRITER_ROUND_EN
    logic [3:0] r4, g4;
    logic [2:0] b3;

    // (v + half) >> k split into high bits plus the first dropped bit
    assign r4  = {1'b0, pix.in_data[15:13]} + {3'b0, pix.in_data[12]};
    assign g4  = {1'b0, pix.in_data[10:8]} + {3'b0, pix.in_data[7]};
    assign b3  = {1'b0, pix.in_data[4:3]} + {2'b0, pix.in_data[2]};
    assign rgb = {r4[3] ? 3'd7 : r4[2:0],
                  g4[3] ? 3'd7 : g4[2:0],
                  b3[2] ? 2'd3 : b3[1:0]};
`else
    assign rgb = {pix.in_data[15:13], pix.in_data[10:8], pix.in_data[4:3]};
`endif

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (enable) state_d = ARMED;
            ARMED: begin
                if (!enable)       state_d = IDLE;
                else if (sof_beat) state_d = ACTIVE;
            end
            ACTIVE:  if (eof && !sof_beat) state_d = enable ? ARMED : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk_12 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge pclk_12 or negedge reset_n) begin
        if (!reset_n) begin
            src_x      <= '0;
            src_y      <= '0;
            line_base  <= '0;
            out_x      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= keep;
            busy       <= (state_d == ACTIVE);
            frame_done <= eof & ~sof_beat;
            if (keep) begin
                wr_addr <= base + ox;
                wr_data <= rgb;
            end
            if (beat) begin
                if (pix.in_eol) begin
                    src_x     <= '0;
                    out_x     <= '0;
                    src_y     <= cy + YW'(1);
                    line_base <= row_kept ? base + AW'(OW) : base;
                end else begin
                    src_x     <= (cx == XW'(SRC_W)) ? cx : cx + XW'(1);
                    out_x     <= keep ? ox + AW'(1) : ox;
                    src_y     <= cy;
                    line_base <= base;
                end
            end
        end
    end
endmodule

// File: tb/tb_ov7670_fb_writer.sv
// Directed bench for ov7670_fb_writer on a scaled 64x48 source, DEC=4.
// Expected addresses/data are computed from the source position of each beat.
module tb_ov7670_fb_writer;
    localparam int W  = 64;
    localparam int H  = 48;
    localparam int D  = 4;
    localparam int AW = 8;
    localparam int OW = W / D;
    localparam int N  = OW * (H / D);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          frame_done;

    ov7670_fb_writer_if pix();

    ov7670_fb_writer #(
        .SRC_W(W), .SRC_H(H), .DEC(D), .AW(AW)
    ) dut (
        .pclk_12   (clk),
        .reset_n   (rst_n),
        .enable    (enable),
        .pix       (pix),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int fd_cyc = -1;
    int eol_cyc = -2;
    int addr_q[$];
    logic [7:0] data_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_en) begin
            addr_q.push_back(int'(wr_addr));
            data_q.push_back(wr_data);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    function automatic logic [7:0] conv(input logic [15:0] d);
        int r, g, b;
`ifdef OV7670_FB_WRITER_ROUND_EN
        r = (int'(d[15:11]) + 2) >> 2;
        g = (int'(d[10:5]) + 4) >> 3;
        b = (int'(d[4:0]) + 4) >> 3;
        if (r > 7) r = 7;
        if (g > 7) g = 7;
        if (b > 3) b = 3;
`else
        r = int'(d[15:13]);
        g = int'(d[10:8]);
        b = int'(d[4:3]);
`endif
        return {r[2:0], g[2:0], b[1:0]};
    endfunction

    function automatic logic [15:0] ramp(input int row, input int col);
        return {row[7:0], col[7:0]};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input bit sof, input bit eol);
        pix.in_valid = 1'b1;
        pix.in_data  = d;
        pix.in_sof   = sof;
        pix.in_eol   = eol;
        @(posedge clk);
        #1;
        if (eol) eol_cyc = cyc;
        pix.in_valid = 1'b0;
        pix.in_sof   = 1'b0;
        pix.in_eol   = 1'b0;
    endtask

    task automatic send_line(input int row, input int len, input bit sof_first);
        for (int c = 0; c < len; c++)
            beat(ramp(row, c), sof_first && c == 0, c == len - 1);
    endtask

    task automatic send_frame(input int rows, input int drop_row);
        for (int r = 0; r < rows; r++) begin
            if (r == drop_row) enable = 1'b0;
            send_line(r, W, r == 0);
        end
    endtask

    task automatic clear_mon();
        addr_q.delete();
        data_q.delete();
        fd_cnt = 0;
        fd_cyc = -1;
    endtask

    task automatic do_reset();
        pix.in_valid = 1'b0;
        pix.in_sof   = 1'b0;
        pix.in_eol   = 1'b0;
        pix.in_data  = '0;
        enable = 1'b0;
        rst_n  = 1'b0;
        idle(2);
        rst_n  = 1'b1;
        idle(1);
        clear_mon();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (wr_en !== 1'b0) begin
            errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en);
        end
        checks++;
        if (wr_addr !== '0) begin
            errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr);
        end
        checks++;
        if (wr_data !== 8'h00) begin
            errors++; $display("FAIL reset_wr_data: got %h want 00", wr_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done);
        end
    endtask

    task automatic test_full_frame();
        int bad, r, c;
        do_reset();
        enable = 1'b1;
        idle(2);
        send_frame(H, -1);
        idle(3);
        checks++;
        if (addr_q.size() !== N) begin
            errors++; $display("FAIL full_count: got %0d want %0d", addr_q.size(), N);
        end
        bad = 0;
        for (int i = 0; i < addr_q.size() && i < N; i++) begin
            r = (i / OW) * D;
            c = (i % OW) * D;
            if (addr_q[i] !== i || data_q[i] !== conv(ramp(r, c))) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL full_order: got %0d bad writes want 0", bad);
        end
        checks++;
        if (fd_cnt !== 1) begin
            errors++; $display("FAIL full_frame_done_count: got %0d want 1", fd_cnt);
        end
        checks++;
        if (fd_cyc !== eol_cyc) begin
            errors++; $display("FAIL full_frame_done_cycle: got %0d want %0d", fd_cyc, eol_cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL full_busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_pixels();
        logic [15:0] vals [3];
        logic [7:0]  exp  [3];
        vals = '{16'hFFFF, 16'hF800, 16'h7BEF};
`ifdef OV7670_FB_WRITER_ROUND_EN
        exp = '{8'hFF, 8'hE0, 8'h92};
`else
        exp = '{8'hFF, 8'hE0, 8'h6D};
`endif
        do_reset();
        enable = 1'b1;
        idle(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL pix_busy_armed: got %b want 0", busy);
        end
        for (int i = 0; i < 3; i++) begin
            beat(vals[i], 1'b1, 1'b0);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== '0 || wr_data !== exp[i]) begin
                errors++;
                $display("FAIL pix_%0d: got en=%b addr=%0d data=%h want en=1 addr=0 data=%h",
                         i, wr_en, wr_addr, wr_data, exp[i]);
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL pix_busy_active: got %b want 1", busy);
        end
        idle(1);
        checks++;
        if (wr_en !== 1'b0 || wr_data !== exp[2]) begin
            errors++;
            $display("FAIL pix_hold: got en=%b data=%h want en=0 data=%h", wr_en, wr_data, exp[2]);
        end
    endtask

    task automatic test_short_line();
        int exp_q[$];
        int bad;
        do_reset();
        enable = 1'b1;
        idle(2);
        send_line(0, 10, 1'b1);
        for (int r = 1; r < 4; r++) send_line(r, 8, 1'b0);
        send_line(4, 70, 1'b0);
        idle(2);
        exp_q = '{0, 1, 2};
        for (int a = 16; a < 32; a++) exp_q.push_back(a);
        checks++;
        if (addr_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL short_count: got %0d want %0d", addr_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < addr_q.size() && i < exp_q.size(); i++)
            if (addr_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL short_addrs: got %0d bad addresses want 0", bad);
        end
        checks++;
        if (fd_cnt !== 0 || busy !== 1'b1) begin
            errors++; $display("FAIL short_state: got fd=%0d busy=%b want fd=0 busy=1", fd_cnt, busy);
        end
    endtask

    task automatic test_sof_restart();
        int bad, e;
        do_reset();
        enable = 1'b1;
        idle(2);
        send_frame(20, -1);
        send_frame(H, -1);
        idle(3);
        checks++;
        if (addr_q.size() !== 80 + N) begin
            errors++; $display("FAIL restart_count: got %0d want %0d", addr_q.size(), 80 + N);
        end
        bad = 0;
        for (int i = 0; i < addr_q.size() && i < 80 + N; i++) begin
            e = (i < 80) ? i : i - 80;
            if (addr_q[i] !== e) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL restart_addrs: got %0d bad addresses want 0", bad);
        end
        checks++;
        if (fd_cnt !== 1 || fd_cyc !== eol_cyc) begin
            errors++;
            $display("FAIL restart_frame_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d",
                     fd_cnt, fd_cyc, eol_cyc);
        end
    endtask

    task automatic test_enable_drop();
        int bad;
        do_reset();
        enable = 1'b1;
        idle(2);
        send_frame(H, 10);
        idle(3);
        checks++;
        if (addr_q.size() !== N) begin
            errors++; $display("FAIL drop_count: got %0d want %0d", addr_q.size(), N);
        end
        bad = 0;
        for (int i = 0; i < addr_q.size() && i < N; i++)
            if (addr_q[i] !== i) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL drop_addrs: got %0d bad addresses want 0", bad);
        end
        checks++;
        if (fd_cnt !== 1 || busy !== 1'b0) begin
            errors++; $display("FAIL drop_end: got fd=%0d busy=%b want fd=1 busy=0", fd_cnt, busy);
        end
        clear_mon();
        send_line(0, W, 1'b1);
        idle(3);
        checks++;
        if (addr_q.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_idle_ignore: got writes=%0d busy=%b want writes=0 busy=0",
                     addr_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1'b1;
        idle(2);
        send_frame(6, -1);
        checks++;
        if (wr_addr !== AW'(31) || busy !== 1'b1) begin
            errors++; $display("FAIL mid_before: got addr=%0d busy=%b want addr=31 busy=1", wr_addr, busy);
        end
        pix.in_valid = 1'b1;
        pix.in_data  = 16'hFFFF;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== 8'h00 ||
            busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got en=%b addr=%0d data=%h busy=%b fd=%b want all 0",
                     wr_en, wr_addr, wr_data, busy, frame_done);
        end
        pix.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        clear_mon();
        send_frame(H, -1);
        idle(3);
        checks++;
        if (addr_q.size() !== N || (addr_q.size() > 0 && addr_q[0] !== 0)) begin
            errors++;
            $display("FAIL mid_next_frame: got count=%0d first=%0d want count=%0d first=0",
                     addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : -1, N);
        end
        checks++;
        if (fd_cnt !== 1) begin
            errors++; $display("FAIL mid_frame_done: got %0d want 1", fd_cnt);
        end
    endtask

    initial begin
        pix.in_valid = 1'b0;
        pix.in_data  = '0;
        pix.in_sof   = 1'b0;
        pix.in_eol   = 1'b0;
        test_reset();
        test_full_frame();
        test_pixels();
        test_short_line();
        test_sof_restart();
        test_enable_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
